mdu_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the MIPS pipeline. It owns the HI/LO registers and executes MULTU and DIVU over WIDTH cycles. Each step drives one add or subtract through a private instance of the team's `alu`, widened by one bit for the carry. The EX stage issues operations with a one-cycle `start` strobe. The hazard logic uses `stall` to hold MFHI/MFLO until the result is valid.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/alu.sv | 33 +++
 rtl/mdu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes,
// MDU operation encodings and the MDU state enum.
package mips_pkg;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_ANDN = 3'd4;
    localparam logic [2:0] ALU_ORN  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    localparam logic [1:0] MDU_MULTU = 2'd0;
    localparam logic [1:0] MDU_DIVU  = 2'd1;
    localparam logic [1:0] MDU_MTHI  = 2'd2;
    localparam logic [1:0] MDU_MTLO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/alu.sv
// Team ALU, SIZE+1 bits wide. Bit 2 of the control
// inverts b and supplies the carry-in for subtract.
module alu #(
    parameter int SIZE = 32
) (
    input  logic [SIZE:0] a,
    input  logic [SIZE:0] b,
    input  logic [2:0]    alu_control,
    output logic [SIZE:0] result
);

    logic [SIZE:0] bb;
    logic [SIZE:0] sum;

    // Operand conditioning and the shared adder.
    always_comb begin
        bb  = alu_control[2] ? ~b : b;
        sum = a + bb + {{SIZE{1'b0}}, alu_control[2]};
    end

    // Function select on the low control bits.
    always_comb begin
        result = '0;
        unique case (alu_control[1:0])
            2'b00: result = a & bb;
            2'b01: result = a | bb;
            2'b10: result = sum;
            2'b11: result = {{SIZE{1'b0}}, sum[SIZE]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULTU/DIVU sequencer owning HI/LO.
// One add/sub step per RUN cycle through a private ALU.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mips_pkg::*;

    localparam int CW = $clog2(WIDTH);

    mdu_state_t state;
    mdu_state_t state_next;

    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;

    logic load;
    logic mthi;
    logic mtlo;
    logic step;
    logic finish;
    logic last;

    logic [WIDTH:0]   alu_a;
    logic [WIDTH:0]   alu_b;
    logic [2:0]       alu_ctl;
    logic [WIDTH:0]   alu_y;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mq_next;

    assign last  = (count == CW'(WIDTH - 1));
    assign stall = rd_hilo & busy;

    // State register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Next state and datapath control strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    unique case (op)
                        MDU_MULTU, MDU_DIVU: begin
                            state_next = RUN;
                            load       = 1'b1;
                        end
                        MDU_MTHI: mthi = 1'b1;
                        MDU_MTLO: mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU operand select: add for MULTU, sub for DIVU.
    always_comb begin
        shifted = {acc, mq[WIDTH-1]};
        alu_a   = {1'b0, acc};
        alu_b   = {1'b0, opnd};
        alu_ctl = ALU_ADD;
        if (is_div) begin
            alu_a   = shifted;
            alu_ctl = ALU_SUB;
        end
    end

    alu #(
        .SIZE(WIDTH)
    ) u_alu (
        .a           (alu_a),
        .b           (alu_b),
        .alu_control (alu_ctl),
        .result      (alu_y)
    );

    // One shift-add or restoring-divide step.
    always_comb begin
        sum      = '0;
        acc_next = acc;
        mq_next  = mq;
        if (is_div) begin
            mq_next  = {mq[WIDTH-2:0], ~alu_y[WIDTH]};
            acc_next = alu_y[WIDTH] ? shifted[WIDTH-1:0]
                                    : alu_y[WIDTH-1:0];
        end else begin
            sum      = mq[0] ? alu_y : {1'b0, acc};
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end
    end

    // Working registers and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            mq     <= '0;
            opnd   <= '0;
        end else if (load) begin
            count  <= '0;
            is_div <= (op == MDU_DIVU);
            acc    <= '0;
            mq     <= (op == MDU_DIVU) ? a : b;
            opnd   <= (op == MDU_DIVU) ? b : a;
        end else if (step) begin
            acc <= acc_next;
            mq  <= mq_next;
            if (!last) begin
                count <= count + CW'(1);
            end
        end
    end

    // HI/LO: written by MTHI/MTLO or on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mthi) begin
            hi <= a;
        end else if (mtlo) begin
            lo <= a;
        end else if (finish) begin
            hi <= acc_next;
            lo <= mq_next;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: arithmetic reference model with a
// per-cycle compare, plus literal directed expectations.
module tb_mdu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rd_hilo;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: result from plain arithmetic,
    // latency as a countdown of remaining edges.
    int           m_left = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    always @(posedge clk) begin
        logic [63:0] p;
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = r_hi;
                    m_lo   = r_lo;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    2'd0: begin
                        p      = 64'(a) * 64'(b);
                        r_hi   = p[63:32];
                        r_lo   = p[31:0];
                        m_left = W;
                    end
                    2'd1: begin
                        if (b == 0) begin
                            r_lo = '1;
                            r_hi = a;
                        end else begin
                            r_lo = a / b;
                            r_hi = a % b;
                        end
                        m_left = W;
                    end
                    2'd2: m_hi = a;
                    default: m_lo = a;
                endcase
            end
        end
        m_busy = (m_left > 0);
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_stall", 64'(stall),
                64'(rd_hilo & m_busy));
            chk("cyc_hi", 64'(hi), 64'(m_hi));
            chk("cyc_lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [1:0] o,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name,
                             output int edges);
        edges = 0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) break;
            if (edges > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: no done within 100 cycles",
                         name);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int dn;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        a       = '0;
        b       = '0;
        rd_hilo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        @(posedge clk);
        #1;

        issue(2'd0, 32'd7, 32'd6);
        chk("mul_busy", 64'(busy), 64'd1);
        wait_done("mul_small", e);
        chk("mul_lat", 64'(e), 64'd32);
        chk("mul_hi", 64'(hi), 64'd0);
        chk("mul_lo", 64'(lo), 64'd42);
        @(posedge clk);
        #1;
        chk("mul_done_pulse", 64'(done), 64'd0);

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mul_max", e);
        chk("max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("max_lo", 64'(lo), 64'h0000_0001);
        @(posedge clk);
        #1;

        issue(2'd1, 32'd100, 32'd7);
        wait_done("div", e);
        chk("div_lo", 64'(lo), 64'd14);
        chk("div_hi", 64'(hi), 64'd2);
        @(posedge clk);
        #1;

        issue(2'd1, 32'h1234, 32'd0);
        wait_done("div0", e);
        chk("div0_lat", 64'(e), 64'd32);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'h1234);
        @(posedge clk);
        #1;

        rd_hilo = 1'b1;
        issue(2'd0, 32'h0001_0000, 32'h0003_0000);
        chk("hz_stall_run", 64'(stall), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        issue(2'd2, 32'hAA, 32'd0);
        chk("hz_hi_hold", 64'(hi), 64'h1234);
        wait_done("hazard", e);
        chk("hz_stall_done", 64'(stall), 64'd0);
        chk("hz_hi", 64'(hi), 64'd3);
        chk("hz_lo", 64'(lo), 64'd0);
        rd_hilo = 1'b0;
        @(posedge clk);
        #1;

        issue(2'd3, 32'h55, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h55);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        issue(2'd0, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);

        issue(2'd0, 32'd3, 32'd3);
        wait_done("b2b_mul", e);
        chk("b2b_lo1", 64'(lo), 64'd9);
        issue(2'd1, 32'd9, 32'd2);
        chk("b2b_busy", 64'(busy), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_lo_hold", 64'(lo), 64'd9);
        wait_done("b2b_div", e);
        chk("b2b_lo2", 64'(lo), 64'd4);
        chk("b2b_hi2", 64'(hi), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
